// File: rtl/rx_pkg.sv
// Shared definitions for the receive sync controller: state encodings,
// default lock/loss thresholds and the keystream width.
package rx_pkg;

    localparam int RX_KEY_W        = 32;
    localparam int RX_LOCK_CNT_DEF = 8;
    localparam int RX_LOSS_CNT_DEF = 4;
    localparam int RX_RUN_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HUNT = 2'd2,
        ST_LOCK = 2'd3
    } rx_state_t;

    // Value a run counter holds on the beat that completes a run of 'thr'
    // words; comparing against this avoids widening the counter by one bit.
    function automatic logic [RX_RUN_W-1:0] rx_last_step(input int thr);
        return RX_RUN_W'(thr - 1);
    endfunction

endpackage

// File: rtl/rx_sync_ctrl_if.sv
// AXI-Stream style input bus of the receive datapath, with sof/eof framing.
interface rx_sync_ctrl_if;
    import rx_pkg::*;

    logic                tvalid;
    logic                tready;
    logic                sof;
    logic                eof;
    logic [RX_KEY_W-1:0] tdata;

    modport master (
        output tvalid,
        output sof,
        output eof,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  sof,
        input  eof,
        input  tdata,
        output tready
    );

endinterface

// File: rtl/rx_sat_counter.sv
// Status counter with synchronous clear; saturates at all-ones or wraps,
// selected by SATURATE. Clear has priority over increment.
module rx_sat_counter #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic             s_axi_aclk,
    input  logic             s_axi_aresetn,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic at_max;

    assign at_max = &count;

    // Counter register: clear wins, saturating mode stops at all-ones.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !(SATURATE && at_max)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/rx_sync_ctrl.sv
// Receive sync sequencer: seeds the PRBS generator, gates the stream input,
// compares each accepted word with the keystream and tracks lock/loss.
module rx_sync_ctrl
    import rx_pkg::*;
#(
    parameter int C_LOCK_CNT  = RX_LOCK_CNT_DEF,
    parameter int C_LOSS_CNT  = RX_LOSS_CNT_DEF,
    parameter int C_CNT_WIDTH = 16
) (
    input  logic                   s_axi_aclk,
    input  logic                   s_axi_aresetn,
    input  logic                   i_enable,
    input  logic [RX_KEY_W-1:0]    i_seed,
    input  logic                   i_clear,
    output logic                   o_prbs_load,
    output logic [RX_KEY_W-1:0]    o_prbs_seed,
    output logic                   o_prbs_advance,
    input  logic [RX_KEY_W-1:0]    i_prbs,
    rx_sync_ctrl_if.slave          s_axis,
    output logic [1:0]             o_state,
    output logic                   o_locked,
    output logic [C_CNT_WIDTH-1:0] o_err_count,
    output logic [C_CNT_WIDTH-1:0] o_frame_count
);

    localparam logic [RX_RUN_W-1:0] LOCK_LAST = rx_last_step(C_LOCK_CNT);
    localparam logic [RX_RUN_W-1:0] LOSS_LAST = rx_last_step(C_LOSS_CNT);

    rx_state_t             state_q, state_d;
    logic [RX_RUN_W-1:0]   match_q, match_d;
    logic [RX_RUN_W-1:0]   miss_q,  miss_d;
    logic                  load_q,  load_d;
    logic                  locked_q;
    logic [RX_KEY_W-1:0]   seed_q;
    logic                  advance;
    logic                  err_inc;
    logic                  frame_inc;
    logic                  beat;
    logic                  match;

    // Ready follows the registered state and is held off while the generator
    // reloads, so the first compared word always sees a fresh keystream.
    assign s_axis.tready  = (state_q != ST_IDLE) && !load_q;
    assign beat           = s_axis.tvalid && s_axis.tready;
    assign match          = (s_axis.tdata == i_prbs);

    assign o_prbs_load    = load_q;
    assign o_prbs_seed    = seed_q;
    assign o_prbs_advance = advance;
    assign o_state        = state_q;
    assign o_locked       = locked_q;

    // Next-state, run counters, reload request and per-beat strobes.
    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        miss_d    = miss_q;
        load_d    = 1'b0;
        advance   = 1'b0;
        err_inc   = 1'b0;
        frame_inc = 1'b0;

        if (!i_enable) begin
            state_d = ST_IDLE;
            match_d = '0;
            miss_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    load_d  = 1'b1;
                    state_d = ST_ARM;
                    match_d = '0;
                    miss_d  = '0;
                end

                ST_ARM: begin
                    // Words before the first sof are dropped without stepping
                    // the generator; a failed sof compare reseeds and retries.
                    if (beat && s_axis.sof) begin
                        advance = 1'b1;
                        if (match) begin
                            if (C_LOCK_CNT == 1) begin
                                state_d = ST_LOCK;
                                match_d = '0;
                            end else begin
                                state_d = ST_HUNT;
                                match_d = RX_RUN_W'(1);
                            end
                        end else begin
                            load_d = 1'b1;
                        end
                    end
                end

                ST_HUNT: begin
                    if (beat) begin
                        advance = 1'b1;
                        if (match) begin
                            if (match_q == LOCK_LAST) begin
                                state_d = ST_LOCK;
                                match_d = '0;
                            end else begin
                                match_d = match_q + RX_RUN_W'(1);
                            end
                        end else begin
                            load_d  = 1'b1;
                            match_d = '0;
                            state_d = ST_ARM;
                        end
                    end
                end

                ST_LOCK: begin
                    if (beat) begin
                        advance   = 1'b1;
                        frame_inc = s_axis.eof;
                        if (match) begin
                            miss_d = '0;
                        end else begin
                            err_inc = 1'b1;
                            if (miss_q == LOSS_LAST) begin
                                load_d  = 1'b1;
                                miss_d  = '0;
                                state_d = ST_ARM;
                            end else begin
                                miss_d = miss_q + RX_RUN_W'(1);
                            end
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control registers: state, run counters, reload pulse, lock flag, seed.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q  <= ST_IDLE;
            match_q  <= '0;
            miss_q   <= '0;
            load_q   <= 1'b0;
            locked_q <= 1'b0;
            seed_q   <= '0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            load_q   <= load_d;
            locked_q <= (state_d == ST_LOCK);
            seed_q   <= i_seed;
        end
    end

    rx_sat_counter #(
        .WIDTH    (C_CNT_WIDTH),
        .SATURATE (1'b1)
    ) u_err_cnt (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_aresetn (s_axi_aresetn),
        .clr           (i_clear),
        .inc           (err_inc),
        .count         (o_err_count)
    );

    rx_sat_counter #(
        .WIDTH    (C_CNT_WIDTH),
        .SATURATE (1'b0)
    ) u_frame_cnt (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_aresetn (s_axi_aresetn),
        .clr           (i_clear),
        .inc           (frame_inc),
        .count         (o_frame_count)
    );

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Bench for rx_sync_ctrl: directed scenarios followed by random traffic,
// all checked against a behavioural model of the sync rules.
module tb_rx_sync_ctrl;

    localparam int LOCK_N = 8;
    localparam int LOSS_N = 4;
    localparam int CW     = 16;

    logic          clk;
    logic          aresetn;
    logic          i_enable;
    logic [31:0]   i_seed;
    logic          i_clear;
    logic          o_prbs_load;
    logic [31:0]   o_prbs_seed;
    logic          o_prbs_advance;
    logic [31:0]   i_prbs;
    logic [1:0]    o_state;
    logic          o_locked;
    logic [CW-1:0] o_err_count;
    logic [CW-1:0] o_frame_count;

    rx_sync_ctrl_if s_axis_if ();

    rx_sync_ctrl #(
        .C_LOCK_CNT  (LOCK_N),
        .C_LOSS_CNT  (LOSS_N),
        .C_CNT_WIDTH (CW)
    ) dut (
        .s_axi_aclk     (clk),
        .s_axi_aresetn  (aresetn),
        .i_enable       (i_enable),
        .i_seed         (i_seed),
        .i_clear        (i_clear),
        .o_prbs_load    (o_prbs_load),
        .o_prbs_seed    (o_prbs_seed),
        .o_prbs_advance (o_prbs_advance),
        .i_prbs         (i_prbs),
        .s_axis         (s_axis_if.slave),
        .o_state        (o_state),
        .o_locked       (o_locked),
        .o_err_count    (o_err_count),
        .o_frame_count  (o_frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Stand-in PRBS generator driven by the DUT's load/advance strobes.
    logic [31:0] gen_key;
    always @(posedge clk or negedge aresetn) begin
        if (!aresetn)            gen_key <= 32'd0;
        else if (o_prbs_load)    gen_key <= o_prbs_seed;
        else if (o_prbs_advance) gen_key <= xs32(gen_key);
    end
    assign i_prbs = gen_key;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: state by name-code, run lengths as integers.
    int          m_state;
    int          m_hits;
    int          m_misses;
    logic        m_load;
    logic        m_locked;
    logic [15:0] m_err;
    logic [15:0] m_frame;
    logic [31:0] m_key;
    logic [31:0] m_seed_reg;
    logic        last_acc;
    int          n_loads;
    int          n_adv;
    int          load_with_ready;

    task automatic model_reset();
        m_state = 0; m_hits = 0; m_misses = 0;
        m_load = 1'b0; m_locked = 1'b0;
        m_err = 16'd0; m_frame = 16'd0;
        m_key = 32'd0; m_seed_reg = 32'd0;
    endtask

    task automatic model_edge(input logic acc, input logic hit, input logic adv);
        logic [31:0] nkey;
        int          ns;
        logic        nl;
        nkey = m_load ? m_seed_reg : (adv ? xs32(m_key) : m_key);
        ns = m_state;
        nl = 1'b0;
        if (i_clear) begin
            m_err = 16'd0;
            m_frame = 16'd0;
        end else if (i_enable && acc && m_state == 3) begin
            if (!hit && m_err != 16'hFFFF) m_err = m_err + 16'd1;
            if (s_axis_if.eof) m_frame = m_frame + 16'd1;
        end
        if (!i_enable) begin
            ns = 0; m_hits = 0; m_misses = 0;
        end else if (m_state == 0) begin
            ns = 1; nl = 1'b1; m_hits = 0; m_misses = 0;
        end else if (acc) begin
            if (m_state == 1) begin
                if (s_axis_if.sof) begin
                    if (hit) begin
                        m_hits = 1;
                        ns = (m_hits >= LOCK_N) ? 3 : 2;
                    end else begin
                        nl = 1'b1;
                    end
                end
            end else if (m_state == 2) begin
                if (hit) begin
                    m_hits++;
                    if (m_hits >= LOCK_N) ns = 3;
                end else begin
                    m_hits = 0; nl = 1'b1; ns = 1;
                end
            end else begin
                if (hit) begin
                    m_misses = 0;
                end else begin
                    m_misses++;
                    if (m_misses >= LOSS_N) begin
                        m_misses = 0; nl = 1'b1; ns = 1;
                    end
                end
            end
        end
        m_key      = nkey;
        m_seed_reg = i_seed;
        m_state    = ns;
        m_load     = nl;
        m_locked   = (ns == 3);
    endtask

    // One clock: check combinational outputs mid-low-phase, clock, check state.
    task automatic cycle();
        logic exp_rdy, acc, hit, exp_adv;
        #1;
        exp_rdy = (m_state != 0) && !m_load;
        acc     = s_axis_if.tvalid && exp_rdy;
        hit     = (s_axis_if.tdata == m_key);
        exp_adv = i_enable && acc && ((m_state == 1 && s_axis_if.sof) || m_state >= 2);
        chk("tready", s_axis_if.tready, exp_rdy);
        chk("advance", o_prbs_advance, exp_adv);
        chk("load", o_prbs_load, m_load);
        if (o_prbs_load) n_loads++;
        if (o_prbs_advance) n_adv++;
        if (o_prbs_load && s_axis_if.tready) load_with_ready++;
        last_acc = acc;
        @(posedge clk);
        model_edge(acc, hit, exp_adv);
        #1;
        chk("state", o_state, m_state[1:0]);
        chk("locked", o_locked, m_locked);
        chk("err_count", o_err_count, m_err);
        chk("frame_count", o_frame_count, m_frame);
        chk("prbs_seed", o_prbs_seed, m_seed_reg);
        @(negedge clk);
    endtask

    // Offer one beat until it is accepted (bounded).
    task automatic send(input logic sof, input logic eof, input logic bad, input logic clr);
        int n;
        n = 0;
        s_axis_if.tvalid = 1'b1;
        s_axis_if.sof    = sof;
        s_axis_if.eof    = eof;
        do begin
            s_axis_if.tdata = bad ? (m_key ^ 32'hA5A5_0F0F) : m_key;
            i_clear = clr;
            cycle();
            n++;
        end while (!last_acc && n < 16);
        s_axis_if.tvalid = 1'b0;
        s_axis_if.sof    = 1'b0;
        s_axis_if.eof    = 1'b0;
        i_clear          = 1'b0;
        if (!last_acc) begin
            checks++;
            errors++;
            $error("FAIL beat_timeout observed=not_accepted expected=accepted");
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tready"}, s_axis_if.tready, 1'b0);
        chk({tag, "_load"}, o_prbs_load, 1'b0);
        chk({tag, "_adv"}, o_prbs_advance, 1'b0);
        chk({tag, "_state"}, o_state, 2'd0);
        chk({tag, "_locked"}, o_locked, 1'b0);
        chk({tag, "_err"}, o_err_count, 16'd0);
        chk({tag, "_frame"}, o_frame_count, 16'd0);
        chk({tag, "_seed"}, o_prbs_seed, 32'd0);
    endtask

    logic [15:0] held_err;
    logic [15:0] held_frame;

    initial begin
        aresetn = 1'b0; i_enable = 1'b0; i_seed = 32'h1; i_clear = 1'b0;
        s_axis_if.tvalid = 1'b0; s_axis_if.sof = 1'b0; s_axis_if.eof = 1'b0;
        s_axis_if.tdata = 32'd0;
        n_loads = 0; n_adv = 0; load_with_ready = 0; last_acc = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        aresetn = 1'b1;

        // Enable with seed 1 and lock on 8 matching words.
        i_enable = 1'b1;
        n_loads = 0; load_with_ready = 0;
        send(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < LOCK_N; i++) begin
            chk("t1_not_yet_locked", o_locked, 1'b0);
            send(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("t1_state", o_state, 2'd3);
        chk("t1_locked", o_locked, 1'b1);
        chk("t1_loads", n_loads, 1);
        chk("t1_ready_in_load", load_with_ready, 0);

        // Loss: bad, good, bad x4 -> 5 errors, back to ARM.
        send(1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b0, 1'b1, 1'b0);
            chk("loss_still_locked", o_state, 2'd3);
        end
        send(1'b0, 1'b0, 1'b1, 1'b0);
        chk("loss_err", o_err_count, 16'd5);
        chk("loss_state", o_state, 2'd1);
        chk("loss_locked", o_locked, 1'b0);
        chk("loss_load", o_prbs_load, 1'b1);

        // Clear the counters.
        i_clear = 1'b1;
        cycle();
        i_clear = 1'b0;
        chk("clear_err", o_err_count, 16'd0);

        // ARM: three non-sof beats are discarded, then a matching sof beat.
        n_adv = 0;
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 1'b0, 1'b0);
        chk("arm_discard_adv", n_adv, 0);
        chk("arm_discard_state", o_state, 2'd1);
        send(1'b1, 1'b0, 1'b0, 1'b0);
        chk("arm_to_hunt", o_state, 2'd2);

        // HUNT: five matches in total, then one corrupt word.
        for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 1'b0, 1'b0);
        n_loads = 0;
        send(1'b0, 1'b0, 1'b1, 1'b0);
        chk("hunt_back_to_arm", o_state, 2'd1);
        chk("hunt_load", o_prbs_load, 1'b1);
        chk("hunt_err_zero", o_err_count, 16'd0);

        // Re-lock: exactly LOCK_N matches are required.
        send(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < LOCK_N - 1; i++) send(1'b0, 1'b0, 1'b0, 1'b0);
        chk("relock_one_short", o_state, 2'd2);
        send(1'b0, 1'b0, 1'b0, 1'b0);
        chk("relock_state", o_state, 2'd3);

        // Three 4-word frames; clear coincides with the second eof.
        for (int f = 0; f < 3; f++) begin
            for (int w = 0; w < 4; w++)
                send(w == 0, w == 3, 1'b0, (f == 1) && (w == 3));
            if (f == 1) chk("frames_clear_wins", o_frame_count, 16'd0);
        end
        chk("frames_count", o_frame_count, 16'd1);

        // Disable mid-frame: IDLE next cycle, counters held, re-enable reloads.
        send(1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b0);
        held_err = o_err_count;
        held_frame = o_frame_count;
        i_enable = 1'b0;
        cycle();
        chk("dis_state", o_state, 2'd0);
        chk("dis_tready", s_axis_if.tready, 1'b0);
        chk("dis_err_held", o_err_count, held_err);
        chk("dis_frame_held", o_frame_count, 16'd1);
        i_enable = 1'b1;
        cycle();
        chk("reen_load", o_prbs_load, 1'b1);
        chk("reen_state", o_state, 2'd1);

        // Asynchronous reset mid-frame.
        send(1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b0);
        s_axis_if.tvalid = 1'b1;
        s_axis_if.tdata  = m_key;
        #2 aresetn = 1'b0;
        i_enable = 1'b0;
        s_axis_if.tvalid = 1'b0;
        #1;
        model_reset();
        i_seed = 32'h1;
        check_zero("midreset");
        @(negedge clk);
        chk("midreset_seed_held", o_prbs_seed, 32'd0);
        aresetn = 1'b1;
        n_loads = 0;
        repeat (3) cycle();
        chk("post_reset_no_load", n_loads, 0);

        // Random traffic against the model.
        i_enable = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (i_enable && $urandom_range(0, 79) == 0) i_enable = 1'b0;
            else if (!i_enable && $urandom_range(0, 3) == 0) i_enable = 1'b1;
            i_clear = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 149) == 0) i_seed = $urandom | 32'h1;
            s_axis_if.tvalid = i_enable && ($urandom_range(0, 3) != 0);
            s_axis_if.sof    = ($urandom_range(0, 1) == 0);
            s_axis_if.eof    = ($urandom_range(0, 3) == 0);
            s_axis_if.tdata  = ($urandom_range(0, 19) == 0) ? (m_key ^ ($urandom | 32'h1)) : m_key;
            cycle();
        end
        i_clear = 1'b0;
        s_axis_if.tvalid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_sync_ctrl.md
Name: rx_sync_ctrl

Overview:
- Sequencer for the receive datapath: loads the PRBS generator seed, gates the AXI-Stream input, and compares each accepted word against the PRBS keystream.
- Declares sync lock or loss and automatically re-arms after loss.
- Sits between the rx AXI-Lite register bank (enable, seed, clear) and the prbs generator / stream input.
- Replaces the free-running enable/tready logic with an explicit state machine plus status counters.

Parameters:
- C_LOCK_CNT, 8, consecutive matching words required in HUNT before entering LOCK (1..255).
- C_LOSS_CNT, 4, consecutive mismatching words in LOCK before declaring loss (1..255).
- C_CNT_WIDTH, 16, width of the error and frame counters.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  asynchronous active-low reset
- i_enable  in  1  receiver enable, level; from register bank
- i_seed  in  32  PRBS seed; from register bank
- i_clear  in  1  single-cycle pulse that clears the error and frame counters
- o_prbs_load  out  1  single-cycle pulse that loads o_prbs_seed into the generator
- o_prbs_seed  out  32  seed value presented to the generator
- o_prbs_advance  out  1  steps the generator by one word
- i_prbs  in  32  current keystream word; valid the cycle after load or advance
- s_axis_tready  out  1  stream ready
- s_axis_tvalid  in  1  stream valid
- s_axis_sof  in  1  start of frame
- s_axis_eof  in  1  end of frame
- s_axis_tdata  in  32  stream data
- o_state  out  2  current FSM state
- o_locked  out  1  high while in LOCK
- o_err_count  out  C_CNT_WIDTH  saturating count of mismatches while in LOCK
- o_frame_count  out  C_CNT_WIDTH  wrapping count of eof beats accepted in LOCK

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Internal match and miss counters 0.
  - o_prbs_seed is 0 at reset and tracks i_seed registered.
- Beat accepted = s_axis_tvalid & s_axis_tready.
- Match = s_axis_tdata == i_prbs, evaluated only on an accepted beat.
- States (o_state encoding): IDLE=0, ARM=1, HUNT=2, LOCK=3.
- IDLE:
  - s_axis_tready=0.
  - When i_enable=1: pulse o_prbs_load for one cycle and go to ARM.
- ARM:
  - s_axis_tready=1.
  - Accepted beats with sof=0 are discarded: no advance, no compare.
  - Accepted beat with sof=1: compare against i_prbs and assert o_prbs_advance in the same cycle.
    - On match, the match counter becomes 1 and state goes to HUNT; if C_LOCK_CNT=1, go directly to LOCK.
    - On mismatch, stay in ARM and pulse o_prbs_load again (reseed).
- HUNT:
  - Every accepted beat asserts o_prbs_advance.
  - On match, increment the match counter; when it reaches C_LOCK_CNT, go to LOCK.
  - On mismatch, pulse o_prbs_load, clear the match counter, and go to ARM.
- LOCK:
  - o_locked=1; every accepted beat advances the generator.
  - On mismatch: increment o_err_count (saturating at all-ones) and the miss counter.
  - On match: clear the miss counter.
  - When the miss counter reaches C_LOSS_CNT: pulse o_prbs_load, clear the miss counter, and go to ARM.
  - An accepted beat with eof=1 increments o_frame_count (wraps), regardless of match result.
- tready rules:
  - Combinational from the registered state: high in ARM, HUNT and LOCK.
  - Forced low during any cycle in which o_prbs_load is high, so the reloaded keystream is valid before the next beat.
- i_enable=0 in any state:
  - Next state is IDLE and tready drops the next cycle.
  - Match and miss counters are cleared; o_err_count and o_frame_count are held.
- i_clear:
  - Zeroes o_err_count and o_frame_count the next cycle.
  - If it coincides with an increment, the clear wins.
- o_locked and o_state are registered; LOCK is visible the cycle after the qualifying beat.
- Reset asserted mid-frame: immediate return to IDLE with all counters 0; no load pulse is issued until i_enable is seen after reset release.

Decomposition:
- Package rx_pkg holds:
  - State encodings (IDLE/ARM/HUNT/LOCK).
  - Default lock and loss thresholds.
  - Keystream width constant (32).
- One sub-module, rx_sat_counter: a parameterised-width saturating/wrapping counter with clear. It is used for o_err_count (saturating) and o_frame_count (wrapping).

Test Plan:
- Enable with seed 0x1 and send 8 matching words starting with sof -> o_prbs_load pulses once, tready low during the load cycle, o_locked=1 the cycle after the 8th beat, o_state=3.
- In ARM, send 3 beats with sof=0, then a sof beat that matches -> first 3 discarded with no o_prbs_advance; state goes to HUNT with the match counter at 1.
- In HUNT after 5 matches, inject 1 corrupt word -> o_prbs_load pulses, state returns to ARM, o_err_count stays 0.
- In LOCK, inject corrupt, good, corrupt, corrupt, corrupt, corrupt -> o_err_count=5, loss declared after the 4th consecutive bad word, state ARM, o_locked=0.
- In LOCK, send 3 frames of 4 words each with eof on the last word, pulsing i_clear on the 2nd eof cycle -> o_frame_count=1 at the end.
- Deassert i_enable mid-frame in LOCK -> IDLE next cycle, tready=0, counters held; re-enable -> new load pulse and state ARM.
